// File: rtl/fifo_buffer_fwft.sv
// First-word-fall-through FIFO with a full-range occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_buffer_fwft #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 5,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  wren_i,
    input  logic                  rden_i,
    input  logic                  flush_i,
    input  logic                  err_clr_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_empty_o,
    output logic                  almost_full_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rd_acc, wr_acc, wr_en;

    // Handshake: a write is taken when wren_i && (!full_o || a read is taken the
    // same cycle); data_o is valid whenever !empty_o and rden_i pops it at the edge.
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == DEPTH_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign almost_full_o  = (count_q >= AF_C);
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;
    assign data_o         = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        rd_acc   = rden_i & ~empty_o;
        wr_acc   = wren_i & (~full_o | rd_acc);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        ovf_d    = err_clr_i ? 1'b0 : ovf_q;
        udf_d    = err_clr_i ? 1'b0 : udf_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_en = wr_acc & ~reset;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (wr_acc & ~rd_acc)      count_d = count_q + CW'(1);
            else if (rd_acc & ~wr_acc) count_d = count_q - CW'(1);
            // A new error event outranks a same-cycle clear.
            if (wren_i & ~wr_acc) ovf_d = 1'b1;
            if (rden_i & ~rd_acc) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end
endmodule
